// File: rtl/cnt_pkg.sv
// Shared definitions for the counter stream block: FSM state encoding and
// default counter range constants.
package cnt_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned DefaultInit  = 111;
    localparam int unsigned DefaultLimit = 333;
    localparam int unsigned DefaultStep  = 1;

endpackage

// File: rtl/cnt_fifo.sv
// First-word-fall-through FIFO; rdata reads as zero while the FIFO is empty.
// Push and pop in the same cycle are legal even when full.
module cnt_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/cnt_stream.sv
// Counter that streams INIT..LIMIT (stepping by STEP, wrapping to INIT) into a
// valid/ready output through a small FWFT FIFO, under start/stop control.
module cnt_stream
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned INIT  = DefaultInit,
    parameter int unsigned LIMIT = DefaultLimit,
    parameter int unsigned STEP  = DefaultStep
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_wrap,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic                       done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic             wrap;
    logic             push, pop, full, empty;

    // One extra bit so the overflow past LIMIT is never lost.
    assign sum  = {1'b0, cnt_q} + (WIDTH+1)'(STEP);
    assign wrap = (sum > (WIDTH+1)'(LIMIT));

    assign pop  = m_valid && m_ready;
    assign push = (state_q == StRun) && (!full || pop);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (empty) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = WIDTH'(INIT);
        end else if (push) begin
            cnt_d = wrap ? WIDTH'(INIT) : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= WIDTH'(INIT);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    cnt_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({wrap, cnt_q}),
        .pop   (pop),
        .rdata ({m_wrap, m_data}),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign m_valid = !empty;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_cnt_stream.sv
// Self-checking bench for cnt_stream: three instances with different counter
// ranges share stimulus; delivered samples are checked against a sequence model.
module tb_cnt_stream;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic m_ready = 1'b0;

    logic        v0, v1, v2;
    logic [15:0] d0, d1, d2;
    logic        wr0, wr1, wr2;
    logic [2:0]  l0, l1, l2;
    logic        b0, b1, b2;
    logic        dn0, dn1, dn2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_stream dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .m_valid(v0),
        .m_ready(m_ready), .m_data(d0), .m_wrap(wr0), .level(l0), .busy(b0), .done(dn0)
    );

    cnt_stream #(.INIT(111), .LIMIT(114), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .m_valid(v1),
        .m_ready(m_ready), .m_data(d1), .m_wrap(wr1), .level(l1), .busy(b1), .done(dn1)
    );

    cnt_stream #(.INIT(0), .LIMIT(10), .STEP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .m_valid(v2),
        .m_ready(m_ready), .m_data(d2), .m_wrap(wr2), .level(l2), .busy(b2), .done(dn2)
    );

    // Reference sequence: value after v, and whether v is the last before wrapping.
    function automatic int next_val(input int v, input int init, input int lim, input int step);
        return (v + step > lim) ? init : v + step;
    endfunction

    function automatic bit wraps(input int v, input int lim, input int step);
        return (v + step > lim);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain_to_idle;
        stop = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            stop = 1'b0;
            if (!b0 && !b1 && !b2) break;
        end
        checks++;
        if (b0 || b1 || b2) begin
            errors++;
            $display("FAIL drain_idle: busy=%b%b%b required 000", b0, b1, b2);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; m_ready = 1'b1;
        tick();
        checks++;
        if ({v0, wr0, b0, dn0} !== 4'b0 || l0 !== 3'd0 || d0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut0: v=%b w=%b b=%b dn=%b l=%0d d=%0d required all 0",
                     v0, wr0, b0, dn0, l0, d0);
        end
        checks++;
        if ({v1, wr1, b1, dn1, v2, wr2, b2, dn2} !== 8'b0 || l1 !== 3'd0 || l2 !== 3'd0
            || d1 !== 16'd0 || d2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut12: outputs not cleared");
        end
        rst_n = 1'b1; start = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_stream;
        do_reset();
        m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (b0 !== 1'b1 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_cycle1: busy=%b valid=%b required 1 0", b0, v0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (v0 !== 1'b1 || d0 !== 16'(111 + i) || l0 > 3'd1) begin
                errors++;
                $display("FAIL stream_data[%0d]: valid=%b data=%0d level=%0d required 1 %0d <=1",
                         i, v0, d0, l0, 111 + i);
            end
        end
        drain_to_idle();
    endtask

    task automatic test_backpressure;
        do_reset();
        m_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++;
        if (l0 !== 3'd4 || v0 !== 1'b1 || d0 !== 16'd111 || dut0.cnt_q !== 16'd115) begin
            errors++;
            $display("FAIL bp_full: level=%0d valid=%b data=%0d cnt=%0d required 4 1 111 115",
                     l0, v0, d0, dut0.cnt_q);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (v0 !== 1'b1 || d0 !== 16'(111 + i)) begin
                errors++;
                $display("FAIL bp_release[%0d]: valid=%b data=%0d required 1 %0d",
                         i, v0, d0, 111 + i);
            end
            tick();
        end
        drain_to_idle();
    endtask

    task automatic test_wrap;
        int got1 = 0;
        int got2 = 0;
        int e1 = 111;
        int e2 = 0;
        do_reset();
        m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (v1 && got1 < 5) begin
                checks++;
                if (d1 !== 16'(e1) || wr1 !== wraps(e1, 114, 1)) begin
                    errors++;
                    $display("FAIL wrap_a[%0d]: data=%0d wrap=%b required %0d %b",
                             got1, d1, wr1, e1, wraps(e1, 114, 1));
                end
                e1 = next_val(e1, 111, 114, 1);
                got1++;
            end
            if (v2 && got2 < 4) begin
                checks++;
                if (d2 !== 16'(e2) || wr2 !== wraps(e2, 10, 4)) begin
                    errors++;
                    $display("FAIL wrap_b[%0d]: data=%0d wrap=%b required %0d %b",
                             got2, d2, wr2, e2, wraps(e2, 10, 4));
                end
                e2 = next_val(e2, 0, 10, 4);
                got2++;
            end
        end
        checks++;
        if (got1 != 5 || got2 != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d/%0d samples required 5/4", got1, got2);
        end
        drain_to_idle();
    endtask

    task automatic test_stop_drain;
        int queued;
        int exp_total;
        int recv = 0;
        int done_cnt = 0;
        int e = 111;
        do_reset();
        m_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        queued = int'(l0);
        checks++;
        if (queued != 3) begin
            errors++;
            $display("FAIL drain_queued: level=%0d required 3", queued);
        end
        stop = 1'b1; m_ready = 1'b1;
        exp_total = queued + ((queued < D || m_ready) ? 1 : 0);
        for (int c = 0; c < 20; c++) begin
            if (v0) begin
                checks++;
                if (d0 !== 16'(e)) begin
                    errors++;
                    $display("FAIL drain_data[%0d]: data=%0d required %0d", recv, d0, e);
                end
                e = next_val(e, 111, 333, 1);
                recv++;
            end
            if (dn0) begin
                done_cnt++;
                checks++;
                if (l0 !== 3'd0 || recv != exp_total) begin
                    errors++;
                    $display("FAIL drain_done_early: level=%0d delivered=%0d required 0 %0d",
                             l0, recv, exp_total);
                end
            end
            if (c > 0 && !b0) break;
            tick();
            stop = 1'b0;
        end
        checks++;
        if (done_cnt != 1 || recv != exp_total || b0 !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: done_cycles=%0d delivered=%0d busy=%b required 1 %0d 0",
                     done_cnt, recv, b0, exp_total);
        end
        drain_to_idle();
    endtask

    task automatic test_start_stop;
        do_reset();
        start = 1'b1; stop = 1'b1; m_ready = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (b0 !== 1'b0 || l0 !== 3'd0 || v0 !== 1'b0) begin
                errors++;
                $display("FAIL start_stop[%0d]: busy=%b level=%0d valid=%b required 0 0 0",
                         c, b0, l0, v0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run;
        int done_seen = 0;
        do_reset();
        m_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (l0 !== 3'd3 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: level=%0d busy=%b required 3 1", l0, b0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (l0 !== 3'd0 || v0 !== 1'b0 || b0 !== 1'b0 || dn0 !== 1'b0 || d0 !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: level=%0d valid=%b busy=%b done=%b data=%0d required 0",
                     l0, v0, b0, dn0, d0);
        end
        for (int c = 0; c < 3; c++) begin
            if (dn0) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrun_done: done pulses=%0d required 0", done_seen);
        end
        m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (v0 !== 1'b1 || d0 !== 16'd111) begin
            errors++;
            $display("FAIL midrun_restart: valid=%b data=%0d required 1 111", v0, d0);
        end
        drain_to_idle();
    endtask

    task automatic test_random;
        int e0 = 111;
        int e1 = 111;
        int e2 = 0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [15:0] pd = '0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            stop = (i == 300);
            checks++;
            if (v0 !== (l0 != 3'd0) || l0 > 3'(D) || (!v0 && (d0 !== 16'd0 || wr0 !== 1'b0))) begin
                errors++;
                $display("FAIL rand_inv[%0d]: valid=%b level=%0d data=%0d wrap=%b",
                         i, v0, l0, d0, wr0);
            end
            if (pv && !pr) begin
                checks++;
                if (v0 !== 1'b1 || d0 !== pd) begin
                    errors++;
                    $display("FAIL rand_stable[%0d]: valid=%b data=%0d required 1 %0d",
                             i, v0, d0, pd);
                end
            end
            m_ready = 1'($urandom_range(0, 1));
            if (v0 && m_ready) begin
                checks++;
                if (d0 !== 16'(e0) || wr0 !== wraps(e0, 333, 1)) begin
                    errors++;
                    $display("FAIL rand_a[%0d]: data=%0d wrap=%b required %0d", i, d0, wr0, e0);
                end
                e0 = next_val(e0, 111, 333, 1);
            end
            if (v1 && m_ready) begin
                checks++;
                if (d1 !== 16'(e1) || wr1 !== wraps(e1, 114, 1)) begin
                    errors++;
                    $display("FAIL rand_b[%0d]: data=%0d wrap=%b required %0d", i, d1, wr1, e1);
                end
                e1 = next_val(e1, 111, 114, 1);
            end
            if (v2 && m_ready) begin
                checks++;
                if (d2 !== 16'(e2) || wr2 !== wraps(e2, 10, 4)) begin
                    errors++;
                    $display("FAIL rand_c[%0d]: data=%0d wrap=%b required %0d", i, d2, wr2, e2);
                end
                e2 = next_val(e2, 0, 10, 4);
            end
            pv = v0; pr = m_ready; pd = d0;
            tick();
            if (i > 300 && !b0 && !b1 && !b2) break;
        end
        stop = 1'b0;
        checks++;
        if (b0 || b1 || b2 || v0 || v1 || v2) begin
            errors++;
            $display("FAIL rand_end: busy=%b%b%b valid=%b%b%b required idle and empty",
                     b0, b1, b2, v0, v1, v2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_stop_drain();
        test_start_stop();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnt_stream.md
CNT_STREAM -- requirements
Module: cnt_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data/counter width.
REQ-002 The block SHALL have parameter DEPTH, default 4, output FIFO entries, power of two, >= 2.
REQ-003 The block SHALL have parameter INIT, default 111, counter start and wrap-to value.
REQ-004 The block SHALL have parameter LIMIT, default 333, highest value emitted; LIMIT >= INIT.
REQ-005 The block SHALL have parameter STEP, default 1, increment per push; 1 <= STEP <= LIMIT-INIT+1.
REQ-006 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-007 The block SHALL have port rst_n, input, 1; reset rst_n, synchronous, active-low.
REQ-008 The block SHALL have port start, input, 1, single-cycle run request.
REQ-009 The block SHALL have port stop, input, 1, single-cycle stop request.
REQ-010 The block SHALL have port m_valid, output, 1, output sample available.
REQ-011 The block SHALL have port m_ready, input, 1, downstream accepts sample.
REQ-012 The block SHALL have port m_data, output, WIDTH, counter sample.
REQ-013 The block SHALL have port m_wrap, output, 1, sample is the last before wrap to INIT.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-015 The block SHALL have port busy, output, 1, state != IDLE.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse on DRAIN->IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-018 IDLE: start=1 and stop=0 -> RUN next cycle; else stay; cnt held at INIT; no pushes.
REQ-019 RUN: stop=1 -> DRAIN next cycle; start ignored; stop wins over start in any state.
REQ-020 DRAIN: no pushes; level==0 -> IDLE, done=1 for that one cycle.
REQ-021 Push SHALL occur in every RUN cycle where level<DEPTH or a pop occurs that cycle; the pushed value is cnt.
REQ-022 Pop SHALL occur when m_valid and m_ready are both 1.
REQ-023 On a push, cnt SHALL become INIT when cnt+STEP > LIMIT, computed in WIDTH+1 bits; otherwise cnt+STEP. Without a push, cnt SHALL hold.
REQ-024 m_wrap SHALL be stored per entry: 1 iff the pushed value caused the wrap per REQ-023.
REQ-025 The FIFO SHALL be first-word-fall-through: a value pushed in cycle N SHALL appear on m_data with m_valid=1 in cycle N+1 when the FIFO was empty.
REQ-026 m_valid SHALL equal (level != 0); m_data and m_wrap SHALL be stable while m_valid=1 and m_ready=0.
REQ-027 Simultaneous push and pop SHALL leave level unchanged, including at level==DEPTH.
REQ-028 No value SHALL be lost or duplicated under any m_ready pattern; full FIFO stalls cnt.
REQ-029 The stop cycle SHALL itself push if REQ-021 holds; pushes end from the next cycle.
REQ-030 m_data and m_wrap SHALL be 0 when m_valid=0.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set state IDLE and cnt=INIT, empty the FIFO, and clear level, m_valid, m_data, m_wrap, busy and done to 0.
REQ-032 Reset mid-RUN or mid-DRAIN SHALL discard queued samples; no done pulse SHALL be produced.

Structure
REQ-033 Package cnt_pkg SHALL hold the state encoding (IDLE=0, RUN=1, DRAIN=2) and the default INIT/LIMIT/STEP constants.
REQ-034 The FIFO SHALL be sub-module cnt_fifo (WIDTH+1 bits wide, DEPTH entries, push/pop/level/full/empty).

Verification
REQ-035 The bench SHALL check: defaults, m_ready=1, start at cycle 0 -> m_data 111,112,113... on consecutive cycles from cycle 2, level<=1.
REQ-036 The bench SHALL check: m_ready=0 for 10 cycles after start -> level=4, m_data holds at 111, cnt stalls at 115; then m_ready=1 -> 111..118 in order with no gaps.
REQ-037 The bench SHALL check: INIT=111, LIMIT=114, STEP=1 -> 111,112,113,114(m_wrap=1),111(m_wrap=0).
REQ-038 The bench SHALL check: INIT=0, LIMIT=10, STEP=4 -> 0,4,8(m_wrap=1),0.
REQ-039 The bench SHALL check: stop with 3 entries queued and m_ready=1 -> exactly the queued values plus any stop-cycle push are delivered, then done=1 for one cycle, busy=0.
REQ-040 The bench SHALL check: start and stop in the same cycle -> stays IDLE; rst_n=0 mid-RUN with level=3 -> next cycle level=0, m_valid=0, cnt restarts at 111.
